// File: rtl/even_parity_tx.sv
// Even-parity frame transmitter: accepts a word over valid/ready, sends it LSB-first
// followed by its parity bit, and presents the latched word and parity in parallel.
module even_parity_tx #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              inj_err,
  output logic              din_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic [DATA_W-1:0] par_data,
  output logic              par_bit,
  output logic              par_valid,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [DATA_W-1:0] par_data_reg, par_data_next;
  logic              par_bit_reg, par_bit_next;
  logic              par_valid_reg, par_valid_next;
  logic              ser_out_reg, ser_out_next;
  logic              ser_valid_reg, ser_valid_next;
  logic              frame_start_reg, frame_start_next;
  logic              frame_end_reg, frame_end_next;
  logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic              accept;

  // A new word may land on the parity cycle so frames run back to back.
  assign din_ready = rst_n && ((state_reg == IDLE) || (state_reg == PARITY));
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      par_data_reg    <= '0;
      par_bit_reg     <= 1'b0;
      par_valid_reg   <= 1'b0;
      ser_out_reg     <= 1'b0;
      ser_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      par_data_reg    <= par_data_next;
      par_bit_reg     <= par_bit_next;
      par_valid_reg   <= par_valid_next;
      ser_out_reg     <= ser_out_next;
      ser_valid_reg   <= ser_valid_next;
      frame_start_reg <= frame_start_next;
      frame_end_reg   <= frame_end_next;
      frame_cnt_reg   <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    par_data_next    = par_data_reg;
    par_bit_next     = par_bit_reg;
    par_valid_next   = 1'b0;
    ser_out_next     = 1'b0;
    ser_valid_next   = 1'b0;
    frame_start_next = 1'b0;
    frame_end_next   = 1'b0;
    frame_cnt_next   = frame_cnt_reg;

    case (state_reg)
      IDLE, PARITY: begin
        if (accept) begin
          state_next = DATA;
          idx_next   = '0;
        end else begin
          state_next = IDLE;
        end
        if (state_reg == PARITY) frame_cnt_next = frame_cnt_reg + CNT_W'(1);
      end
      DATA: begin
        if (idx_reg == LAST_IDX) state_next = PARITY;
        else                     idx_next   = idx_reg + IDX_W'(1);
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      par_data_next  = din;
      par_bit_next   = (^din) ^ inj_err;
      par_valid_next = 1'b1;
    end

    // Outputs are registered against the state being entered, giving one-cycle latency.
    case (state_next)
      DATA: begin
        ser_out_next     = par_data_next[idx_next];
        ser_valid_next   = 1'b1;
        frame_start_next = (idx_next == '0);
      end
      PARITY: begin
        ser_out_next   = par_bit_next;
        ser_valid_next = 1'b1;
        frame_end_next = 1'b1;
      end
      default: ;
    endcase
  end

  assign ser_out     = ser_out_reg;
  assign ser_valid   = ser_valid_reg;
  assign frame_start = frame_start_reg;
  assign frame_end   = frame_end_reg;
  assign par_data    = par_data_reg;
  assign par_bit     = par_bit_reg;
  assign par_valid   = par_valid_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_even_parity_tx.sv
// Self-checking bench for even_parity_tx: table-driven frames with a serial scoreboard,
// back-to-back, asynchronous reset mid-frame, counter wrap and a DATA_W=1 instance.
module tb_even_parity_tx;
  localparam int DW = 3;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_valid, inj_err;
  logic          din_ready, ser_out, ser_valid, frame_start, frame_end;
  logic [DW-1:0] par_data;
  logic          par_bit, par_valid;
  logic [CW-1:0] frame_cnt;

  logic [0:0] din1, par_data1;
  logic       din_valid1, inj_err1, din_ready1, ser_out1, ser_valid1;
  logic       frame_start1, frame_end1, par_bit1, par_valid1;
  logic [7:0] frame_cnt1;

  even_parity_tx #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .inj_err(inj_err),
    .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .frame_end(frame_end), .par_data(par_data),
    .par_bit(par_bit), .par_valid(par_valid), .frame_cnt(frame_cnt)
  );

  even_parity_tx #(.DATA_W(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(din_valid1), .inj_err(inj_err1),
    .din_ready(din_ready1), .ser_out(ser_out1), .ser_valid(ser_valid1),
    .frame_start(frame_start1), .frame_end(frame_end1), .par_data(par_data1),
    .par_bit(par_bit1), .par_valid(par_valid1), .frame_cnt(frame_cnt1)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_pv  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {logic b; logic s; logic e;} ser_t;
  ser_t          q[$];
  ser_t          mon_e;
  logic [CW-1:0] exp_cnt = '0;
  bit            prev_end = 1'b0;

  // Serial scoreboard: one expected entry per frame bit, popped when ser_valid is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt  = '0;
      prev_end = 1'b0;
    end else begin
      if (prev_end) exp_cnt = exp_cnt + 1'b1;
      prev_end = 1'b0;
      check("frame_cnt", frame_cnt, exp_cnt);
      if (par_valid) n_pv++;
      if (ser_valid) begin
        if (q.size() == 0) check("unexpected ser_valid", ser_valid, 0);
        else begin
          mon_e = q.pop_front();
          $display("bit: ser_out=%0b start=%0b end=%0b exp=%0b/%0b/%0b",
                   ser_out, frame_start, frame_end, mon_e.b, mon_e.s, mon_e.e);
          check("ser_out", ser_out, mon_e.b);
          check("frame_start", frame_start, mon_e.s);
          check("frame_end", frame_end, mon_e.e);
          check("din_ready in frame", din_ready, mon_e.e);
          prev_end = mon_e.e;
        end
      end else begin
        check("idle outputs", {ser_out, frame_start, frame_end}, 0);
        check("idle din_ready", din_ready, 1);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic inj, input logic p);
    int w = 0;
    din = d; inj_err = inj; din_valid = 1'b1;
    while (!din_ready && w < 50) begin @(negedge clk); w++; end
    if (!din_ready) begin
      check("accept timeout", din_ready, 1);
      din_valid = 1'b0;
      return;
    end
    for (int i = 0; i < DW; i++) q.push_back('{b: d[i], s: (i == 0), e: 1'b0});
    q.push_back('{b: p, s: 1'b0, e: 1'b1});
    n_acc++;
    @(negedge clk);
    din_valid = 1'b0; inj_err = 1'b0;
    $display("accept: din=%03b inj=%0b -> par_data=%03b par_bit=%0b par_valid=%0b exp_par=%0b",
             d, inj, par_data, par_bit, par_valid, p);
    check("par_valid", par_valid, 1);
    check("par_data", par_data, d);
    check("par_bit", par_bit, p);
    check("checker parity", ^{par_data, par_bit}, inj);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " ser_out"}, ser_out, 0);
    check({nm, " ser_valid"}, ser_valid, 0);
    check({nm, " frame_start"}, frame_start, 0);
    check({nm, " frame_end"}, frame_end, 0);
    check({nm, " par_data"}, par_data, 0);
    check({nm, " par_bit"}, par_bit, 0);
    check({nm, " par_valid"}, par_valid, 0);
    check({nm, " frame_cnt"}, frame_cnt, 0);
    check({nm, " din_ready"}, din_ready, 0);
  endtask

  typedef struct {logic [DW-1:0] d; logic inj; logic p;} vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{3'b111, 1'b0, 1'b1};
    tbl[1] = '{3'b101, 1'b0, 1'b0};
    tbl[2] = '{3'b000, 1'b0, 1'b0};
    tbl[3] = '{3'b001, 1'b1, 1'b0};
    tbl[4] = '{3'b010, 1'b0, 1'b1};
    tbl[5] = '{3'b100, 1'b1, 1'b0};

    rst_n = 1'b1; din = '0; din_valid = 1'b0; inj_err = 1'b0;
    din1 = '0; din_valid1 = 1'b0; inj_err1 = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].inj, tbl[i].p);
      repeat (6) @(negedge clk);
    end

    // Back-to-back: second accept lands on the first frame's parity cycle.
    send(3'b110, 1'b0, 1'b0);
    send(3'b011, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("cnt after 8 frames", frame_cnt, 2'd0);

    // Single-bit instance: one DATA cycle then one PARITY cycle.
    din1 = 1'b1; inj_err1 = 1'b0; din_valid1 = 1'b1;
    check("w1 din_ready", din_ready1, 1);
    @(negedge clk);
    din_valid1 = 1'b0;
    $display("w1 frame A: ser_out=%0b start=%0b", ser_out1, frame_start1);
    check("w1 bit0", {ser_valid1, ser_out1, frame_start1, frame_end1, par_valid1}, 5'b11101);
    @(negedge clk);
    check("w1 parity", {ser_valid1, ser_out1, frame_start1, frame_end1, din_ready1}, 5'b11011);
    @(negedge clk);
    check("w1 cnt", frame_cnt1, 8'd1);
    check("w1 idle", ser_valid1, 0);
    din1 = 1'b0; inj_err1 = 1'b1; din_valid1 = 1'b1;
    @(negedge clk);
    din_valid1 = 1'b0; inj_err1 = 1'b0;
    $display("w1 frame B: ser_out=%0b par_bit=%0b", ser_out1, par_bit1);
    check("w1 inj bit0", {ser_valid1, ser_out1, frame_start1, par_bit1}, 4'b1011);
    @(negedge clk);
    check("w1 inj parity", {ser_valid1, ser_out1, frame_end1}, 3'b111);
    @(negedge clk);
    check("w1 cnt2", frame_cnt1, 8'd2);

    // Reset during bit 1 must clear outputs without a clock edge.
    send(3'b101, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid-frame reset");
    check("w1 reset cnt", frame_cnt1, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post-reset din_ready", din_ready, 1);
    check("post-reset frame_cnt", frame_cnt, 0);
    @(negedge clk);
    send(3'b011, 1'b0, 1'b0);
    repeat (6) @(negedge clk);

    begin
      int w = 0;
      while (q.size() != 0 && w < 50) begin @(negedge clk); w++; end
    end
    check("queue drained", q.size(), 0);
    check("par_valid pulses", n_pv, n_acc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
